tdm_demux_1x8: RTL
==================

// Module: tdm_demux_1x8
// PURPOSE
//  Receive-side partner of the 8:1 channel multiplexer. Takes a time-division
//  sample stream (channel 0 marked by din_sync, then channels 1..7 in order)
//  and fans the samples out to 8 parallel channel lanes. Each full frame is
//  presented as one registered 8-lane word with a valid/ready handshake.
//  Sits between the serial link and per-channel consumers.
// PARAMETERS
//  WIDTH   8   bits per channel sample
// PORTS
//  clk          in   1         single clock; all state changes on posedge
//  rst_n        in   1         asynchronous, active-low reset
//  din          in   WIDTH     TDM sample
//  din_valid    in   1         din valid this cycle (no input backpressure)
//  din_sync     in   1         qualifies din as channel 0 (frame start)
//  dout         out  8*WIDTH   frame; lane k = dout[k*WIDTH +: WIDTH]
//  frame_valid  out  1         dout holds an unconsumed frame
//  frame_ready  in   1         consumer accepts dout
//  ch_idx       out  3         channel the next non-sync sample is written to
//  frame_err    out  1         1-cycle pulse: sync arrived mid-frame
//  overrun      out  1         1-cycle pulse: completed frame dropped
// BEHAVIOUR
//  Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
//  Reset: state=HUNT, ch_idx=0, hold regs=0, dout=0, frame_valid=0,
//   frame_err=0, overrun=0. Reset mid-frame discards the partial frame and
//   the pending frame.
//  FSM, 2 states:
//   HUNT: din_valid&din_sync -> hold[0]<=din, ch_idx<=1, go FILL.
//         din_valid&!din_sync -> sample ignored silently. No flag.
//   FILL: din_valid&!din_sync -> hold[ch_idx]<=din, ch_idx<=ch_idx+1.
//         If ch_idx==7 the frame completes: ch_idx<=0, go HUNT.
//         din_valid&din_sync (ch_idx 1..7) -> frame_err pulse,
//         partial frame discarded, hold[0]<=din, ch_idx<=1, stay FILL.
//  Frame completion at edge N (ch7 sample accepted):
//   - slot free (!frame_valid, or frame_ready at edge N): dout<={din,hold[6..0]}
//     and frame_valid=1 from edge N. Latency is 1 clock from the ch7 sample.
//   - slot busy (frame_valid & !frame_ready): new frame dropped, overrun
//     pulses for 1 cycle. dout and frame_valid are unchanged.
//  Handshake: transfer when frame_valid&frame_ready at a posedge.
//   frame_valid then clears, unless a frame completes on that same edge;
//   in that case frame_valid stays 1 with the new dout. dout is stable
//   while frame_valid=1 and not transferred.
//  din is don't-care when din_valid=0. No state changes when din_valid=0.
//  ch_idx wraps 7->0 only via completion. It never exceeds 7.
// STRUCTURE
//  Shared package: NUM_CH=8, CH_W=3, state encoding (ST_HUNT, ST_FILL).
//  Sub-module demux_1x8: combinational 3-to-8 write-enable decoder,
//   ports (en, sel[2:0], we[7:0]). It drives the hold-register enables.
//  Top module: FSM, ch_idx counter, hold regs, output slot, and flag pulses.
// TESTING
//  1 Reset, then sync+0x10, then 0x11..0x17 with frame_ready=1 ->
//    frame_valid=1 one clock after 0x17. dout lanes 0..7 = 0x10..0x17.
//    ch_idx=0.
//  2 Stream 0x05,0x06 without sync after reset -> ignored. ch_idx=0,
//    no flags, frame_valid=0.
//  3 sync+0xA0, 0xA1, 0xA2, then sync+0xB0, then 0xB1..0xB7 -> frame_err
//    pulses once at the 2nd sync. Output frame = 0xB0..0xB7.
//  4 Frame A completes with frame_ready=0; frame B then completes ->
//    overrun pulses. dout still holds frame A.
//  5 frame_ready=1 on the edge frame B's ch7 arrives -> frame A transferred.
//    frame_valid stays 1 with dout = frame B. No overrun.
//  6 Assert rst_n=0 asynchronously after ch3 of a frame -> all outputs 0
//    at once. Next sync starts a clean frame.

Source files
------------

// File: rtl/tdm_demux_1x8_pkg.sv
// Shared constants and state encoding for the 1:8 TDM demultiplexer.
package tdm_demux_1x8_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned CH_W   = 3;

  // Index of the channel whose sample closes a frame
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_FILL = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_demux_1x8_demux.sv
// 3-to-8 one-hot write-enable decoder for the channel hold registers.
module demux_1x8
  import tdm_demux_1x8_pkg::*;
(
  input  logic              en,
  input  logic [CH_W-1:0]   sel,
  output logic [NUM_CH-1:0] we
);

  always_comb begin
    we = '0;
    if (en) we[sel] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux_1x8.sv
// Receive-side TDM demultiplexer: collects channels 0..7 of a sync-marked
// sample stream and presents each complete frame as one registered word.
module tdm_demux_1x8
  import tdm_demux_1x8_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        din,
  input  logic                    din_valid,
  input  logic                    din_sync,
  output logic [NUM_CH*WIDTH-1:0] dout,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic [CH_W-1:0]         ch_idx,
  output logic                    frame_err,
  output logic                    overrun
);

  localparam int unsigned FRAME_W = NUM_CH * WIDTH;

  state_t              state, state_nxt;
  logic [CH_W-1:0]     ch_idx_nxt;
  logic                hold_en;
  logic [CH_W-1:0]     hold_sel;
  logic [NUM_CH-1:0]   hold_we;
  logic [WIDTH-1:0]    hold [NUM_CH-1];
  logic                complete;
  logic                slot_free;
  logic                load;
  logic                frame_valid_nxt;
  logic                frame_err_nxt;
  logic                overrun_nxt;
  logic [FRAME_W-1:0]  frame_nxt;

  demux_1x8 u_demux (
    .en  (hold_en),
    .sel (hold_sel),
    .we  (hold_we)
  );

  // FSM state, channel counter and frame flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_HUNT;
      ch_idx      <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
      dout        <= '0;
    end else begin
      state       <= state_nxt;
      ch_idx      <= ch_idx_nxt;
      frame_valid <= frame_valid_nxt;
      frame_err   <= frame_err_nxt;
      overrun     <= overrun_nxt;
      if (load) dout <= frame_nxt;
    end
  end

  // Hold registers for channels 0..6; channel 7 goes straight to dout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_CH - 1; k++) hold[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CH - 1; k++) begin
        if (hold_we[k]) hold[k] <= din;
      end
    end
  end

  // Next state, counter and hold-register write selection
  always_comb begin
    state_nxt     = state;
    ch_idx_nxt    = ch_idx;
    hold_en       = 1'b0;
    hold_sel      = ch_idx;
    frame_err_nxt = 1'b0;
    case (state)
      ST_HUNT: begin
        if (din_valid && din_sync) begin
          hold_en    = 1'b1;
          hold_sel   = '0;
          ch_idx_nxt = CH_W'(1);
          state_nxt  = ST_FILL;
        end
      end
      ST_FILL: begin
        if (din_valid) begin
          hold_en = 1'b1;
          if (din_sync) begin
            // Resync mid-frame: drop the partial frame and restart at ch0
            hold_sel      = '0;
            ch_idx_nxt    = CH_W'(1);
            frame_err_nxt = 1'b1;
          end else if (ch_idx == LAST_CH) begin
            ch_idx_nxt = '0;
            state_nxt  = ST_HUNT;
          end else begin
            ch_idx_nxt = ch_idx + CH_W'(1);
          end
        end
      end
      default: state_nxt = ST_HUNT;
    endcase
  end

  // Output slot: load on completion when free, otherwise flag the drop
  always_comb begin
    complete  = hold_we[NUM_CH-1];
    slot_free = !frame_valid || frame_ready;
    load      = complete && slot_free;
    overrun_nxt = complete && !slot_free;
    if (load)             frame_valid_nxt = 1'b1;
    else if (frame_ready) frame_valid_nxt = 1'b0;
    else                  frame_valid_nxt = frame_valid;
    frame_nxt = '0;
    for (int unsigned k = 0; k < NUM_CH - 1; k++) begin
      frame_nxt[k*WIDTH +: WIDTH] = hold[k];
    end
    frame_nxt[(NUM_CH-1)*WIDTH +: WIDTH] = din;
  end

endmodule
